// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM state type and the inverse S-box table.
`default_nettype none

package aes_pkg;

   localparam int STATE_W = 128;
   localparam int COL_W   = 32;

   typedef logic [0:0] fsm_t;
   localparam fsm_t IDLE = 1'b0;
   localparam fsm_t SUB  = 1'b1;

   // Row-major FIPS-197 inverse S-box; element 0 is the leftmost byte.
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
      return INV_SBOX[b];
   endfunction

endpackage

`default_nettype wire

// File: rtl/inv_sbox.sv
// inv_sbox: combinational single-byte inverse S-box lookup.
`default_nettype none

module inv_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   assign out_byte = inv_sub_byte(in_byte);

endmodule

`default_nettype wire

// File: rtl/inv_sub_bytes.sv
// inv_sub_bytes: AES InvSubBytes stage, column-iterative (4 clocks) by default,
// fully parallel (1 clock) when INV_SUB_BYTES_PARALLEL_EN is defined.
`default_nettype none

module inv_sub_bytes
   import aes_pkg::*;
(
   input  logic               clock,
   input  logic               resetN,
   input  logic               startTransition,
   input  logic [STATE_W-1:0] inputData,
   output logic [STATE_W-1:0] outputData,
   output logic               busy,
   output logic               dataValid
);

   fsm_t               state;
   logic [STATE_W-1:0] work;

`ifdef INV_SUB_BYTES_PARALLEL_EN
   logic [STATE_W-1:0] sub_all;

   for (genvar i = 0; i < STATE_W / 8; i++) begin : g_byte
      inv_sbox u_inv_sbox (
         .in_byte  (work[8*i +: 8]),
         .out_byte (sub_all[8*i +: 8])
      );
   end
`else
   logic [1:0]       cnt;
   logic [COL_W-1:0] col_in;
   logic [COL_W-1:0] col_out;

   // cnt 0 selects [127:96], cnt 3 selects [31:0].
   assign col_in = work[{~cnt, 5'b0} +: COL_W];

   for (genvar i = 0; i < COL_W / 8; i++) begin : g_col_byte
      inv_sbox u_inv_sbox (
         .in_byte  (col_in[8*i +: 8]),
         .out_byte (col_out[8*i +: 8])
      );
   end
`endif

   assign busy = (state == SUB);

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state      <= IDLE;
         work       <= '0;
         outputData <= '0;
         dataValid  <= 1'b0;
`ifndef INV_SUB_BYTES_PARALLEL_EN
         cnt        <= 2'd0;
`endif
      end else begin
         dataValid <= 1'b0;
         case (state)
            IDLE: begin
               if (startTransition) begin
                  work  <= inputData;
                  state <= SUB;
`ifndef INV_SUB_BYTES_PARALLEL_EN
                  cnt   <= 2'd0;
`endif
               end
            end
            SUB: begin
`ifdef INV_SUB_BYTES_PARALLEL_EN
               outputData <= sub_all;
               dataValid  <= 1'b1;
               state      <= IDLE;
`else
               work[{~cnt, 5'b0} +: COL_W] <= col_out;
               cnt                         <= cnt + 2'd1;
               // Last column bypasses work so outputData never sees a partial state.
               if (cnt == 2'd3) begin
                  outputData <= {work[STATE_W-1:COL_W], col_out};
                  dataValid  <= 1'b1;
                  state      <= IDLE;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/inv_sub_bytes.md
INV_SUB_BYTES -- requirements
Module: inv_sub_bytes

Interface
REQ-001 The block SHALL have one parameter: none; all widths SHALL be fixed (128-bit state, 32-bit column).
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 resetN  input  1  asynchronous, active-low reset.
REQ-004 startTransition  input  1  request strobe; level sampled on each rising edge of clock.
REQ-005 inputData  input  128  AES state from the inverse shift-row stage, byte 0 in [127:120].
REQ-006 outputData  output  128  registered state after InvSubBytes.
REQ-007 busy  output  1  high while a substitution is in progress.
REQ-008 dataValid  output  1  one-cycle pulse marking outputData as updated.

Function
REQ-009 FSM states SHALL be IDLE and SUB; reset state SHALL be IDLE.
REQ-010 In IDLE with startTransition=1, inputData SHALL be captured into a working register, the column counter SHALL be cleared to 0, and the FSM SHALL enter SUB.
REQ-011 In SUB, each cycle SHALL replace one 32-bit column of the working register with its inverse-S-box image through 4 byte lookups, in the order [127:96], [95:64], [63:32], [31:0], with the counter as index.
REQ-012 On the edge that completes column 3, outputData SHALL load the fully substituted state, dataValid SHALL be 1 for exactly the following cycle, and the FSM SHALL return to IDLE.
REQ-013 Latency SHALL be 4 clocks from the capture edge to the outputData update edge; throughput SHALL be one state per 5 clocks.
REQ-014 busy SHALL be 1 in SUB and 0 in IDLE.
REQ-015 startTransition while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-016 startTransition in the cycle dataValid=1 (FSM in IDLE) SHALL be accepted as a new request.
REQ-017 outputData SHALL hold its value between completions; partial results SHALL never appear on outputData.
REQ-018 Counter wrap SHALL NOT occur; the counter SHALL be 2 bits and SHALL leave SUB on value 3.

Reset
REQ-019 resetN=0 SHALL immediately force outputData=0, busy=0, dataValid=0, counter=0, working register=0, FSM=IDLE.
REQ-020 Reset asserted mid-SUB SHALL abort the operation with no dataValid pulse; the first request after release SHALL behave as from power-up.

Configuration
REQ-021 Macro INV_SUB_BYTES_PARALLEL_EN SHALL select the datapath style.
REQ-022 With INV_SUB_BYTES_PARALLEL_EN defined, 16 inv_sbox instances SHALL substitute all bytes at once: outputData loads on the edge after capture (latency 1), busy is high for that one cycle, and the handshake rules are unchanged.
REQ-023 Without the macro, the 4-lookup iterative datapath of REQ-011..REQ-013 SHALL be built.

Structure
REQ-024 A shared package aes_pkg SHALL hold the STATE_W=128 and COL_W=32 constants, the FSM state typedef, and the 256-entry inverse S-box constant table.
REQ-025 A combinational sub-module inv_sbox (8-bit in, 8-bit out, table from aes_pkg) SHALL be instantiated 4 times (16 times with the macro).

Verification
REQ-026 inputData=all 0x00, one-cycle startTransition -> after 4 clocks, outputData=all 0x52 and dataValid pulses once.
REQ-027 inputData=all 0x63 -> outputData=all 0x00; bytes 0x01->0x09, 0x7C->0x01, 0xFF->0x7D map correctly in mixed columns.
REQ-028 startTransition held high for 10 clocks -> exactly two completions, at clocks 4 and 9 after the first capture; second-request data taken at the dataValid cycle.
REQ-029 resetN pulsed low at counter=2 -> outputs 0 at once, no dataValid; a new request afterwards completes correctly.
REQ-030 Random 1000 states checked against a reference model in both macro settings -> results identical and latency 4 vs 1.
